// File: rtl/commit_checker.sv
// Self-checker for processor writeback traffic: compares retired register writes,
// in order, against a preloaded table of expected (addr, data) commits.
module commit_checker #(
    parameter int DATA_W       = 32,
    parameter int ADDR_W       = 5,
    parameter int DEPTH        = 16,
    parameter int SKIP_COMMITS = 1,
    parameter int IGNORE_ZERO  = 1,
    parameter int TIMEOUT      = 1024,
    localparam int IDX_W       = $clog2(DEPTH),
    localparam int CNT_W       = IDX_W + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              exp_wr_en,
    input  logic [IDX_W-1:0]  exp_wr_idx,
    input  logic [ADDR_W-1:0] exp_wr_addr,
    input  logic [DATA_W-1:0] exp_wr_data,
    input  logic [CNT_W-1:0]  num_tests,
    input  logic              start,
    input  logic              commit_valid,
    input  logic [ADDR_W-1:0] commit_addr,
    input  logic [DATA_W-1:0] commit_data,
    output logic              busy,
    output logic              done,
    output logic              timed_out,
    output logic [CNT_W-1:0]  pass_count,
    output logic [CNT_W-1:0]  fail_count,
    output logic              fail_valid,
    output logic [IDX_W-1:0]  fail_idx
);

    localparam int SKIP_W = (SKIP_COMMITS > 0) ? $clog2(SKIP_COMMITS + 1) : 1;
    localparam int TO_W   = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE,
        SKIP,
        CHECK,
        DONE
    } state_t;

    state_t              state;
    logic [ADDR_W-1:0]   tab_addr [DEPTH];
    logic [DATA_W-1:0]   tab_data [DEPTH];
    logic [IDX_W-1:0]    idx;
    logic [CNT_W-1:0]    n_tests;
    logic [SKIP_W-1:0]   skip_cnt;
    logic [TO_W-1:0]     to_cnt;

    logic                accept;
    logic                idle_or_done;
    logic [CNT_W-1:0]    n_clamped;
    logic                match;
    logic                last_entry;
    logic                timeout_hit;
    logic [CNT_W-1:0]    remaining;

    assign accept       = commit_valid && !((IGNORE_ZERO != 0) && (commit_addr == '0));
    assign idle_or_done = (state == IDLE) || (state == DONE);
    assign n_clamped    = (num_tests > CNT_W'(DEPTH)) ? CNT_W'(DEPTH) : num_tests;
    assign match        = (tab_addr[idx] == commit_addr) && (tab_data[idx] == commit_data);
    assign last_entry   = ({1'b0, idx} == (n_tests - CNT_W'(1)));
    assign timeout_hit  = (to_cnt == TO_W'(TIMEOUT - 1));
    assign remaining    = n_tests - {1'b0, idx};

    assign busy = (state == SKIP) || (state == CHECK);
    assign done = (state == DONE);

    // Table is deliberately left unreset so a reset between runs keeps the loaded program.
    always_ff @(posedge clk) begin
        if (exp_wr_en && idle_or_done) begin
            tab_addr[exp_wr_idx] <= exp_wr_addr;
            tab_data[exp_wr_idx] <= exp_wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            idx        <= '0;
            n_tests    <= '0;
            skip_cnt   <= '0;
            to_cnt     <= '0;
            timed_out  <= 1'b0;
            pass_count <= '0;
            fail_count <= '0;
            fail_valid <= 1'b0;
            fail_idx   <= '0;
        end else begin
            fail_valid <= 1'b0;
            unique case (state)
                IDLE, DONE: begin
                    if (start) begin
                        idx        <= '0;
                        n_tests    <= n_clamped;
                        skip_cnt   <= SKIP_W'(SKIP_COMMITS);
                        to_cnt     <= '0;
                        timed_out  <= 1'b0;
                        pass_count <= '0;
                        fail_count <= '0;
                        if (n_clamped == '0) begin
                            state <= DONE;
                        end else if (SKIP_COMMITS == 0) begin
                            state <= CHECK;
                        end else begin
                            state <= SKIP;
                        end
                    end
                end
                SKIP: begin
                    // An accepted commit always beats a timeout landing in the same cycle.
                    if (accept) begin
                        to_cnt   <= '0;
                        skip_cnt <= skip_cnt - SKIP_W'(1);
                        if (skip_cnt == SKIP_W'(1)) begin
                            state <= CHECK;
                        end
                    end else if (timeout_hit) begin
                        state      <= DONE;
                        timed_out  <= 1'b1;
                        fail_count <= fail_count + remaining;
                    end else begin
                        to_cnt <= to_cnt + TO_W'(1);
                    end
                end
                CHECK: begin
                    if (accept) begin
                        to_cnt <= '0;
                        if (match) begin
                            pass_count <= pass_count + CNT_W'(1);
                        end else begin
                            fail_count <= fail_count + CNT_W'(1);
                            fail_valid <= 1'b1;
                            fail_idx   <= idx;
                        end
                        if (last_entry) begin
                            state <= DONE;
                        end else begin
                            idx <= idx + IDX_W'(1);
                        end
                    end else if (timeout_hit) begin
                        state      <= DONE;
                        timed_out  <= 1'b1;
                        fail_count <= fail_count + remaining;
                    end else begin
                        to_cnt <= to_cnt + TO_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
